// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared state type and default sizing for the clock-divider controller
package clkdiv_pkg;

  localparam int CNT_W_DEF       = 27;
  localparam int DEFAULT_DIV_DEF = 50_000_000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

endpackage

// File: rtl/clkdiv_counter.sv
// rtl/clkdiv_counter.sv - half-period divide counter with terminal-count flag
module clkdiv_counter
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] div,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  assign tc = (count == div - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clkdiv_ctrl.sv
// rtl/clkdiv_ctrl.sv - run/stop FSM, ratio handshake and registered clk_out/tick generation
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             cfg_err
);

  state_t           state;
  state_t           state_nxt;
  logic             running;
  logic             tc;
  logic             go_idle;
  logic             xfer;
  logic             apply;
  logic             pending_vld;
  logic [CNT_W-1:0] pending;
  logic [CNT_W-1:0] div_active;
  logic [CNT_W-1:0] count_unused;

  assign running = (state != IDLE);
  assign busy    = running;

  // A stop only lands on IDLE while clk_out is low or about to fall, so no runt high pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && !stop) state_nxt = RUN;
      end
      RUN: begin
        if (stop) state_nxt = (!clk_out || tc) ? IDLE : STOPPING;
      end
      STOPPING: begin
        if (start && !stop) state_nxt = RUN;
        else if (tc)        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign go_idle = running && (state_nxt == IDLE);
  assign xfer    = cfg_valid && cfg_ready;
  assign apply   = pending_vld && ((running && tc) || go_idle || !running);

  clkdiv_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (running),
    .clr   (go_idle),
    .div   (div_active),
    .count (count_unused),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      clk_out     <= 1'b0;
      tick        <= 1'b0;
      div_active  <= CNT_W'(DEFAULT_DIV);
      pending     <= '0;
      pending_vld <= 1'b0;
      cfg_ready   <= 1'b1;
      cfg_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      tick  <= running && tc && !clk_out && !go_idle;

      if (go_idle)            clk_out <= 1'b0;
      else if (running && tc) clk_out <= !clk_out;

      // pending_vld keeps cfg_ready low, so a transfer and an apply never share a cycle.
      if (xfer) begin
        if (cfg_div == '0) begin
          cfg_err <= 1'b1;
        end else if (!running) begin
          div_active <= cfg_div;
        end else begin
          pending     <= cfg_div;
          pending_vld <= 1'b1;
          cfg_ready   <= 1'b0;
        end
      end

      if (apply) begin
        div_active  <= pending;
        pending_vld <= 1'b0;
        cfg_ready   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb/tb_clkdiv_ctrl.sv - scoreboard bench for clkdiv_ctrl with CNT_W=8, DEFAULT_DIV=4
module tb_clkdiv_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic             cfg_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_tick[$];

  clkdiv_ctrl #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every tick must match the next scheduled cycle and coincide with clk_out high.
  always @(negedge clk) begin
    if (tick === 1'b1) begin
      check("tick_expected", (exp_tick.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_tick.size() > 0) check("tick_cycle", cyc, exp_tick.pop_front());
      check("tick_clk_out", clk_out, 32'd1);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run(output int ce);
    start = 1'b1;
    step(1);
    start = 1'b0;
    ce = cyc;
  endtask

  task automatic stop_now();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  task automatic check_wave(input string tag, input int half, input int c0, input int n);
    for (int i = 0; i < n; i++) begin
      check(tag, clk_out, ((c0 + i) / half) % 2);
      step(1);
    end
  endtask

  task automatic do_reset();
    check("queue_drained", exp_tick.size(), 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    int ce;
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    step(3);
    check("rst_clk_out", clk_out, 0);
    check("rst_tick", tick, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_cfg_err", cfg_err, 0);
    rst = 1'b0;
    step(1);

    // Basic run: rise 4 cycles after start, period 8, then stop in the low half.
    start_run(ce);
    exp_tick.push_back(ce + 4);
    exp_tick.push_back(ce + 12);
    exp_tick.push_back(ce + 20);
    check("s1_busy", busy, 1);
    check_wave("s1_wave", 4, 0, 24);
    stop_now();
    check("s1_stop_low_busy", busy, 0);
    check("s1_stop_low_clk", clk_out, 0);
    step(4);
    check("s1_idle_clk", clk_out, 0);

    // Ratio change at count=1: current half stays 4, later halves are 2.
    start_run(ce);
    exp_tick.push_back(ce + 4);
    exp_tick.push_back(ce + 8);
    exp_tick.push_back(ce + 12);
    step(1);
    cfg_valid = 1'b1;
    cfg_div   = 8'd2;
    step(1);
    cfg_valid = 1'b0;
    check("s2_ready_low_a", cfg_ready, 0);
    step(1);
    check("s2_ready_low_b", cfg_ready, 0);
    check("s2_half_kept", clk_out, 0);
    step(1);
    check("s2_ready_back", cfg_ready, 1);
    check_wave("s2_wave", 2, 2, 10);
    stop_now();
    check("s2_idle_busy", busy, 0);
    do_reset();

    // Stop while high: full 4-cycle high pulse, then IDLE with busy low.
    start_run(ce);
    exp_tick.push_back(ce + 4);
    step(5);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("s3_stopping_busy", busy, 1);
    check("s3_stopping_clk_a", clk_out, 1);
    step(1);
    check("s3_stopping_clk_b", clk_out, 1);
    step(1);
    check("s3_idle_clk", clk_out, 0);
    check("s3_idle_busy", busy, 0);
    step(8);

    // start and stop together in IDLE: stop wins.
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    check("s4_both_busy", busy, 0);
    step(6);
    check("s4_both_clk", clk_out, 0);

    // start during STOPPING resumes without disturbing phase.
    start_run(ce);
    exp_tick.push_back(ce + 4);
    exp_tick.push_back(ce + 12);
    exp_tick.push_back(ce + 20);
    step(5);
    stop = 1'b1;
    step(1);
    stop  = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("s4_resume_busy", busy, 1);
    check_wave("s4_wave", 4, 7, 17);
    stop_now();
    check("s4_idle_busy", busy, 0);

    // Zero ratio: transfer completes, error sticky, period stays 8.
    cfg_valid = 1'b1;
    cfg_div   = 8'd0;
    step(1);
    cfg_valid = 1'b0;
    check("s5_err_set", cfg_err, 1);
    check("s5_ready", cfg_ready, 1);
    start_run(ce);
    exp_tick.push_back(ce + 4);
    exp_tick.push_back(ce + 12);
    check_wave("s5_wave", 4, 0, 16);
    stop_now();
    check("s5_idle_busy", busy, 0);
    check("s5_err_sticky", cfg_err, 1);

    // Ratio 1: clk_out toggles every cycle, tick every second cycle.
    cfg_valid = 1'b1;
    cfg_div   = 8'd1;
    step(1);
    cfg_valid = 1'b0;
    start_run(ce);
    exp_tick.push_back(ce + 1);
    exp_tick.push_back(ce + 3);
    exp_tick.push_back(ce + 5);
    exp_tick.push_back(ce + 7);
    check_wave("s5_div1_wave", 1, 0, 8);
    stop_now();
    check("s5_div1_busy", busy, 0);
    check("s5_div1_clk", clk_out, 0);
    check("s5_div1_err", cfg_err, 1);

    // Reset mid-run with a pending ratio: defaults restored, pending dropped.
    cfg_valid = 1'b1;
    cfg_div   = 8'd6;
    step(1);
    cfg_valid = 1'b0;
    start_run(ce);
    step(1);
    cfg_valid = 1'b1;
    cfg_div   = 8'd2;
    step(1);
    cfg_valid = 1'b0;
    check("s6_pending_ready", cfg_ready, 0);
    do_reset();
    check("s6_rst_clk_out", clk_out, 0);
    check("s6_rst_tick", tick, 0);
    check("s6_rst_busy", busy, 0);
    check("s6_rst_cfg_ready", cfg_ready, 1);
    check("s6_rst_cfg_err", cfg_err, 0);
    start_run(ce);
    exp_tick.push_back(ce + 4);
    exp_tick.push_back(ce + 12);
    check_wave("s6_wave", 4, 0, 16);
    stop_now();
    step(2);
    check("final_queue_drained", exp_tick.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clkdiv_ctrl.md
# clkdiv_ctrl

Run/stop and ratio controller for the team's clock-divider datapath. It owns the divide counter and generates a glitch-free divided square wave `clk_out` plus a one-cycle `tick` enable. It accepts new divide ratios over a valid/ready handshake and applies them only at half-period boundaries. It sits between the board clock and the sequence-detector logic, which consumes `tick` as its slow-rate enable.

## Interface
- `CNT_W`, 27: width of the divide counter and of `cfg_div`.
- `DEFAULT_DIV`, 50_000_000: half-period in `clk` cycles after reset. Must be ≥1 and < 2^CNT_W.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level-sampled run request.
- `stop`  in  1  level-sampled stop request.
- `cfg_valid`  in  1  new ratio offered.
- `cfg_div`  in  CNT_W  requested half-period in cycles.
- `cfg_ready`  out  1  controller can accept a ratio.
- `clk_out`  out  1  divided clock; registered.
- `tick`  out  1  one-cycle pulse coincident with each 0→1 of `clk_out`.
- `busy`  out  1  high in RUN or STOPPING.
- `cfg_err`  out  1  sticky flag: a zero ratio was offered.

## Operation
- States:
  - IDLE: counter held at 0, `clk_out`=0.
  - RUN: counting.
  - STOPPING: counting; waits for the falling edge of `clk_out`.
- Counter behaviour in RUN/STOPPING:
  - Counter increments each cycle.
  - Terminal count (TC) is `count == div_active-1`.
  - At TC: count←0 and `clk_out` toggles.
  - Period is 2×`div_active` cycles.
- State transitions:
  - IDLE + `start` (and not `stop`) → RUN; count restarts at 0.
  - RUN + `stop`:
    - if `clk_out`=0 → IDLE next cycle, count←0;
    - else → STOPPING.
  - STOPPING at TC (the 1→0 toggle) → IDLE.
  - STOPPING + `start` (not `stop`) → RUN; no disturbance to count or `clk_out`.
  - `start` and `stop` together: `stop` wins. `start` in RUN is ignored.
- Configuration handshake:
  - Transfer occurs when `cfg_valid && cfg_ready`.
  - IDLE: `div_active` ← `cfg_div` next cycle; `cfg_ready` stays 1.
  - RUN/STOPPING: value goes to a `pending` register and `cfg_ready` falls next cycle.
  - At the next TC, `div_active` ← `pending`. The new ratio governs the following half-period.
  - `cfg_ready` rises the cycle after the apply.
  - `pending` is never overwritten.
  - Return to IDLE with a pending value: the value is applied in that same cycle.
- `cfg_div`=0:
  - The transfer completes; the value is discarded and `div_active` is unchanged.
  - `cfg_err` sets the next cycle and clears only on `rst`.
- `div_active`=1: `clk_out` toggles every cycle and `tick` fires every second cycle.

## Timing
- Reset values:
  - state IDLE; count 0; `div_active`=`DEFAULT_DIV`; no pending.
  - `clk_out`=0, `tick`=0, `busy`=0, `cfg_ready`=1, `cfg_err`=0.
- `rst` asserted in any state returns all of the above on the next edge. This is allowed mid-period; the truncated `clk_out` high pulse is accepted.
- Start latency: `start` sampled at edge E → `busy`=1 after E. The first `clk_out` rise and `tick` are `div_active` cycles after E.
- `tick` is registered and high exactly one cycle per period, in the same cycle `clk_out` first reads 1.
- Stop never produces a runt `clk_out` high pulse. Worst-case stop latency is `div_active` cycles.
- `busy` falls in the same cycle `clk_out` falls at the end of STOPPING.

## Structure
- Package `clkdiv_pkg`: state enum (IDLE, RUN, STOPPING), default `CNT_W`, default `DEFAULT_DIV`.
- Sub-module `clkdiv_counter`:
  - Inputs: `clk`, `rst`, `en`, `clr`, `div`.
  - Outputs: `count`, `tc`.
  - Controller holds the FSM, handshake, `pending` and output registers.

## Test plan
All scenarios use `CNT_W`=8, `DEFAULT_DIV`=4.
- Reset, then `start` pulse → `clk_out` rises 4 cycles later, period 8, `tick` one cycle per period, `busy`=1.
- In RUN at count=1, offer `cfg_div`=2 → `cfg_ready` low until the next TC. Current half-period stays 4; following half-periods are 2; `cfg_ready` rises the cycle after the apply.
- `stop` while `clk_out`=1 → STOPPING, `clk_out` high pulse completes its full 4 cycles, then IDLE with `busy`=0. `stop` while `clk_out`=0 → IDLE next cycle.
- `start` and `stop` asserted together in IDLE → remains IDLE. `start` during STOPPING → back to RUN with no change to `clk_out` phase.
- `cfg_div`=0 offered → handshake completes, `cfg_err`=1 sticky, period unchanged at 8. `cfg_div`=1 in IDLE, then `start` → `clk_out` toggles every cycle.
- `rst` pulsed mid-RUN with a pending config → all outputs at reset values next cycle; `div_active` returns to 4 and the pending config is discarded.
